ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYC, default 27, meaning clock cycles ram_cen is held low per access.
REQ-002 SHALL have parameter GAP_CYC, default 2, meaning idle cycles (all strobes high) after each access.
REQ-003 SHALL have parameter B_MAX_WAIT, default 8, meaning consecutive A grants tolerated while b_req pending.
REQ-004 clk_100MHz  in  1  sole clock, all logic on rising edge.
REQ-005 rstn  in  1  synchronous, active-low reset.
REQ-006 a_req / a_we  in  1 / 1  audio requester: request held until a_ack; 1=write.
REQ-007 a_addr / a_wdata  in  27 / 16  audio address, write data.
REQ-008 a_ack / a_rdata  out  1 / 16  one-cycle completion pulse; read data valid while a_ack=1.
REQ-009 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same directions and widths as A  background requester (delete sweep, host).
REQ-010 ram_a / ram_dq_i  out  27 / 16  SRAM-style address, write data to Ram2Ddr.
REQ-011 ram_dq_o  in  16  read data from Ram2Ddr.
REQ-012 ram_cen / ram_oen / ram_wen  out  1 each  active-low strobes.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> GAP -> IDLE; no other transitions except reset.
REQ-015 IDLE, no request: SHALL remain IDLE, strobes high.
REQ-016 IDLE, request(s) present in cycle N: SHALL grant, latch we/addr/wdata of winner into ram_a/ram_dq_i, enter ACCESS at N+1.
REQ-017 Arbitration: A wins over B unless b_wait_cnt == B_MAX_WAIT, in which case B wins.
REQ-018 b_wait_cnt (width >= clog2(B_MAX_WAIT+1)) SHALL increment on each A grant while b_req=1, clear on B grant, and clear whenever b_req=0.
REQ-019 ACCESS: ram_cen=0 for exactly ACC_CYC cycles (N+1..N+ACC_CYC); ram_oen=0 same cycles for reads only; ram_wen=0 same cycles for writes only; the unused strobe stays 1.
REQ-020 Read: SHALL capture ram_dq_o into the winner's rdata on the last ACCESS cycle (N+ACC_CYC).
REQ-021 SHALL pulse the winner's ack for exactly one cycle at N+ACC_CYC+1, coincident with the first GAP cycle; the loser's ack stays 0.
REQ-022 Write ack SHALL leave rdata unchanged; each rdata holds its value until its next read completes.
REQ-023 GAP: all strobes high for GAP_CYC cycles, then IDLE; earliest next grant at N+ACC_CYC+GAP_CYC+1.
REQ-024 Address/data fields SHALL be sampled only at grant; changes during ACCESS/GAP are ignored.
REQ-025 Request dropped after grant: access SHALL complete and ack SHALL still pulse.
REQ-026 Requester holding req through its ack cycle SHALL be treated as a new request at the next IDLE.
REQ-027 ram_a and ram_dq_i SHALL hold the last granted values through GAP and IDLE.
REQ-028 GAP_CYC=0 SHALL be legal (ACCESS -> IDLE directly); ACC_CYC SHALL be >= 1.

Reset
REQ-029 rstn=0 at any clock edge SHALL force IDLE, ram_cen/oen/wen=1, a_ack=b_ack=0, a_rdata=b_rdata=0, ram_a=0, ram_dq_i=0, b_wait_cnt=0, busy=0.
REQ-030 Reset mid-ACCESS SHALL abort the access at that edge with no ack generated afterwards.

Structure
REQ-031 looper_pkg SHALL hold RAM_ADDR_W=27, RAM_DATA_W=16 and the FSM state type (IDLE, ACCESS, GAP).
REQ-032 Single flat module with one shared down-counter for ACCESS and GAP; no sub-module.

Verification
REQ-033 Single A read at addr 0x0000010, ram_dq_o=0x1234 -> cen/oen low 27 cycles, wen high, a_ack at grant+28, a_rdata=0x1234.
REQ-034 A and B asserted same cycle, B write 0x7FFF -> A served first; B granted at grant+30 (27+2+1), B ack 28 cycles later, wen low for B only.
REQ-035 A held continuously with b_req=1 -> exactly 8 A grants then 1 B grant, repeating; b_wait_cnt never exceeds 8.
REQ-036 b_req dropped after 3 A grants, reasserted -> counter cleared, B waits a full 8 further A grants.
REQ-037 rstn low at ACCESS cycle 10 -> next edge strobes high, busy=0, no ack ever pulses; fresh request afterwards completes normally.
REQ-038 a_addr changed at grant+5 -> ram_a keeps originally latched address through ack.

Source files
------------

// File: rtl/looper_pkg.sv
// Shared widths and state encoding for the SRAM port arbiter.
// The arbiter is a single flat module that imports this package.
package looper_pkg;

    localparam int RAM_ADDR_W = 27;
    localparam int RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        GAP
    } state_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the Ram2Ddr SRAM-style interface.
// A has priority; B is forced through after B_MAX_WAIT A grants.
module ram_port_arbiter
    import looper_pkg::*;
#(
    parameter int ACC_CYC    = 27,
    parameter int GAP_CYC    = 2,
    parameter int B_MAX_WAIT = 8
) (
    input  logic                  clk_100MHz,
    input  logic                  rstn,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [RAM_ADDR_W-1:0] a_addr,
    input  logic [RAM_DATA_W-1:0] a_wdata,
    output logic                  a_ack,
    output logic [RAM_DATA_W-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [RAM_ADDR_W-1:0] b_addr,
    input  logic [RAM_DATA_W-1:0] b_wdata,
    output logic                  b_ack,
    output logic [RAM_DATA_W-1:0] b_rdata,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [RAM_DATA_W-1:0] ram_dq_i,
    input  logic [RAM_DATA_W-1:0] ram_dq_o,
    output logic                  ram_cen,
    output logic                  ram_oen,
    output logic                  ram_wen,
    output logic                  busy
);

    localparam int CNT_MAX = (ACC_CYC > GAP_CYC) ? ACC_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WAIT_W  = (B_MAX_WAIT > 0) ? $clog2(B_MAX_WAIT + 1) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WAIT_W-1:0] b_wait_cnt;
    logic              owner_b;
    logic              cur_we;
    logic              pick_b;
    logic              win_we;

    assign pick_b = b_req & (~a_req | (b_wait_cnt == WAIT_W'(B_MAX_WAIT)));
    assign win_we = pick_b ? b_we : a_we;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk_100MHz) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            b_wait_cnt <= '0;
            owner_b    <= 1'b0;
            cur_we     <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            ram_a      <= '0;
            ram_dq_i   <= '0;
            ram_cen    <= 1'b1;
            ram_oen    <= 1'b1;
            ram_wen    <= 1'b1;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req | b_req) begin
                        state    <= ACCESS;
                        cnt      <= CNT_W'(ACC_CYC - 1);
                        owner_b  <= pick_b;
                        cur_we   <= win_we;
                        ram_a    <= pick_b ? b_addr : a_addr;
                        ram_dq_i <= pick_b ? b_wdata : a_wdata;
                        ram_cen  <= 1'b0;
                        ram_oen  <= win_we;
                        ram_wen  <= ~win_we;
                        if (pick_b)
                            b_wait_cnt <= '0;
                        else if (b_req)
                            b_wait_cnt <= b_wait_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        ram_cen <= 1'b1;
                        ram_oen <= 1'b1;
                        ram_wen <= 1'b1;
                        if (owner_b) begin
                            b_ack <= 1'b1;
                            if (!cur_we) b_rdata <= ram_dq_o;
                        end else begin
                            a_ack <= 1'b1;
                            if (!cur_we) a_rdata <= ram_dq_o;
                        end
                        if (GAP_CYC == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                            cnt   <= CNT_W'(GAP_CYC - 1);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
            // A dropped B request forfeits any accumulated wait credit
            if (!b_req) b_wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: vector table plus
// hand-written multi-access and reset sequences.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rstn;
    logic        a_req, a_we, b_req, b_we;
    logic [26:0] a_addr, b_addr, ram_a;
    logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic [15:0] ram_dq_i, ram_dq_o;
    logic        a_ack, b_ack, ram_cen, ram_oen, ram_wen, busy;

    int tests = 0;
    int fails = 0;

    ram_port_arbiter dut (
        .clk_100MHz(clk),
        .rstn(rstn),
        .a_req(a_req),
        .a_we(a_we),
        .a_addr(a_addr),
        .a_wdata(a_wdata),
        .a_ack(a_ack),
        .a_rdata(a_rdata),
        .b_req(b_req),
        .b_we(b_we),
        .b_addr(b_addr),
        .b_wdata(b_wdata),
        .b_ack(b_ack),
        .b_rdata(b_rdata),
        .ram_a(ram_a),
        .ram_dq_i(ram_dq_i),
        .ram_dq_o(ram_dq_o),
        .ram_cen(ram_cen),
        .ram_oen(ram_oen),
        .ram_wen(ram_wen),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_b;
        bit          we;
        bit          drop;
        logic [26:0] addr;
        logic [15:0] wd;
        logic [15:0] dq;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_single(input vec_t v, input string nm);
        int cen_n, oen_n, wen_n, ack_at, acks, lose;
        logic [26:0] ra;
        logic [15:0] rd;
        bit win, los;
        cen_n = 0; oen_n = 0; wen_n = 0;
        ack_at = 0; acks = 0; lose = 0;
        ra = '0; rd = '0;
        @(negedge clk);
        ram_dq_o = ~v.dq;
        if (v.is_b) begin
            b_req = 1; b_we = v.we; b_addr = v.addr; b_wdata = v.wd;
        end else begin
            a_req = 1; a_we = v.we; a_addr = v.addr; a_wdata = v.wd;
        end
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (!ram_cen) cen_n++;
            if (!ram_oen) oen_n++;
            if (!ram_wen) wen_n++;
            win = v.is_b ? b_ack : a_ack;
            los = v.is_b ? a_ack : b_ack;
            if (win) begin
                acks++;
                if (ack_at == 0) ack_at = k;
                ra = ram_a;
                rd = ram_dq_i;
            end
            if (los) lose++;
            if (k == 5) begin
                a_we = ~a_we; a_addr = ~a_addr; a_wdata = ~a_wdata;
                b_we = ~b_we; b_addr = ~b_addr; b_wdata = ~b_wdata;
            end
            if (k == 27) ram_dq_o = v.dq;
            if (k == 28) ram_dq_o = ~v.dq;
            if (win || (k == 1 && v.drop)) begin
                a_req = 0; b_req = 0;
            end
        end
        check({nm, " cen cycles"}, cen_n, 27);
        check({nm, " oen cycles"}, oen_n, v.we ? 0 : 27);
        check({nm, " wen cycles"}, wen_n, v.we ? 27 : 0);
        check({nm, " ack cycle"}, ack_at, 28);
        check({nm, " ack count"}, acks, 1);
        check({nm, " loser ack"}, lose, 0);
        check({nm, " ram_a at ack"}, ra, v.addr);
        check({nm, " ram_dq_i at ack"}, rd, v.wd);
        check({nm, " a_rdata"}, a_rdata, v.ea);
        check({nm, " b_rdata"}, b_rdata, v.eb);
        check({nm, " busy end"}, busy, 0);
    endtask

    initial begin
        int n, maxc, a_at, b_at, cen_n, wen_n, oen_n, wen_first, acks;
        logic [26:0] ra;
        logic [15:0] rd;

        vecs[0] = '{0, 0, 0, 27'h0000010, 16'h0000, 16'h1234, 16'h1234, 16'h0000};
        vecs[1] = '{1, 0, 0, 27'h0005555, 16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[2] = '{0, 1, 0, 27'h7ABCDEF, 16'h55AA, 16'hFFFF, 16'h1234, 16'hBEEF};
        vecs[3] = '{1, 1, 1, 27'h0000001, 16'h7FFF, 16'h0F0F, 16'h1234, 16'hBEEF};
        vecs[4] = '{0, 0, 1, 27'h7FFFFFF, 16'hA5A5, 16'h0000, 16'h0000, 16'hBEEF};
        vecs[5] = '{1, 0, 0, 27'h0000000, 16'h1357, 16'hFFFF, 16'h0000, 16'hFFFF};

        rstn = 0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        ram_dq_o = 16'hDEAD;
        repeat (3) @(negedge clk);
        check("rst strobes", {ram_cen, ram_oen, ram_wen}, 3'b111);
        check("rst acks", {a_ack, b_ack}, 2'b00);
        check("rst rdata", {a_rdata, b_rdata}, 32'h0);
        check("rst ram_a", ram_a, 0);
        check("rst ram_dq_i", ram_dq_i, 0);
        check("rst busy", busy, 0);
        rstn = 1;
        repeat (2) @(negedge clk);
        check("idle strobes", {ram_cen, ram_oen, ram_wen}, 3'b111);
        check("idle busy", busy, 0);

        for (int i = 0; i < 6; i++)
            run_single(vecs[i], $sformatf("v%0d", i));

        // A and B together: A first, then B write
        @(negedge clk);
        ram_dq_o = 16'h1111;
        a_we = 0; a_addr = 27'h20; a_wdata = 16'h0;
        b_we = 1; b_addr = 27'h30; b_wdata = 16'h7FFF;
        a_req = 1; b_req = 1;
        a_at = 0; b_at = 0; cen_n = 0; wen_n = 0; oen_n = 0;
        wen_first = 0; ra = '0; rd = '0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (!ram_cen) cen_n++;
            if (!ram_oen) oen_n++;
            if (!ram_wen) begin
                wen_n++;
                if (wen_first == 0) wen_first = k;
            end
            if (a_ack) begin
                if (a_at == 0) a_at = k;
                a_req = 0;
            end
            if (b_ack) begin
                if (b_at == 0) b_at = k;
                ra = ram_a; rd = ram_dq_i;
                b_req = 0;
            end
        end
        check("both a_ack cycle", a_at, 28);
        check("both b_ack cycle", b_at, 58);
        check("both cen cycles", cen_n, 54);
        check("both oen cycles", oen_n, 27);
        check("both wen cycles", wen_n, 27);
        check("both wen first", wen_first, 31);
        check("both b ram_a", ra, 27'h30);
        check("both b ram_dq_i", rd, 16'h7FFF);
        check("both a_rdata", a_rdata, 16'h1111);
        check("both b_rdata", b_rdata, 16'hFFFF);

        // Continuous contention: 8 A grants, then one B
        @(negedge clk);
        ram_dq_o = 16'h0;
        a_req = 1; b_req = 1;
        n = 0; maxc = 0;
        for (int k = 0; k < 800 && n < 18; k++) begin
            @(negedge clk);
            if (int'(dut.b_wait_cnt) > maxc) maxc = int'(dut.b_wait_cnt);
            if (a_ack || b_ack) begin
                check($sformatf("starve ack%0d is_b", n), b_ack,
                      (n % 9) == 8);
                n++;
            end
        end
        a_req = 0; b_req = 0;
        check("starve ack total", n, 18);
        check("starve max wait", maxc, 8);
        repeat (5) @(negedge clk);

        // B drops after 3 A grants and returns: full wait restarts
        a_req = 1; b_req = 1;
        n = 0;
        for (int k = 0; k < 600 && n < 13; k++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                check($sformatf("drop ack%0d is_b", n), b_ack, n == 12);
                n++;
                if (n == 3) b_req = 0;
                if (n == 4) b_req = 1;
            end
        end
        a_req = 0; b_req = 0;
        check("drop ack total", n, 13);
        repeat (5) @(negedge clk);

        // Reset in the middle of an access
        a_we = 0; a_addr = 27'h44; a_wdata = 16'h9999;
        ram_dq_o = 16'h4321;
        a_req = 1;
        repeat (10) @(negedge clk);
        check("mid access cen", ram_cen, 0);
        rstn = 0; a_req = 0;
        @(negedge clk);
        check("mid rst strobes", {ram_cen, ram_oen, ram_wen}, 3'b111);
        check("mid rst busy", busy, 0);
        check("mid rst a_rdata", a_rdata, 0);
        check("mid rst ram_a", ram_a, 0);
        rstn = 1;
        acks = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_ack || b_ack) acks++;
        end
        check("mid rst no ack", acks, 0);
        run_single('{0, 0, 0, 27'h0000010, 16'h0000, 16'h1234,
                     16'h1234, 16'h0000}, "post rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
